// File: rtl/pmem_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pmem_line_buffer
// Function : single-line write-back buffer between a 32-bit CPU port and a
//            256-bit physical memory port, with saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_line_buffer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      mem_address,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_byte_enable,
    output logic             mem_resp,
    output logic [31:0]      mem_rdata,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [31:0]      pmem_address,
    output logic [255:0]     pmem_wdata,
    input  logic             pmem_resp,
    input  logic [255:0]     pmem_rdata,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WB      = 2'd1;
    localparam logic [1:0] c_ST_FILL    = 2'd2;
    localparam logic [1:0] c_ST_RESPOND = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [255:0]     line_q,  line_d;
    logic [26:0]      tag_q,   tag_d;
    logic             valid_q, valid_d;
    logic             dirty_q, dirty_d;
    logic [CNT_W-1:0] hit_q,   hit_d;
    logic [CNT_W-1:0] miss_q,  miss_d;

    logic             w_req;
    logic             w_hit;
    logic             w_is_write;
    logic [7:0]       w_bit_idx;
    logic [31:0]      w_word;
    logic [31:0]      w_merged;
    logic             w_unused_addr;

    assign w_req         = mem_read | mem_write;
    assign w_hit         = valid_q && (tag_q == mem_address[31:5]);
    assign w_is_write    = mem_write && !mem_read;
    assign w_bit_idx     = {mem_address[4:2], 5'b0};
    assign w_word        = line_q[w_bit_idx +: 32];
    assign w_unused_addr = &{1'b0, mem_address[1:0]};

    always_comb begin
        w_merged = w_word;
        for (int i = 0; i < 4; i++) begin
            if (mem_byte_enable[i]) begin
                w_merged[8*i +: 8] = mem_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        state_d = c_ST_RESPOND;
                        hit_d   = (hit_q == '1) ? hit_q : hit_q + c_CNT_ONE;
                    end else begin
                        state_d = dirty_q ? c_ST_WB : c_ST_FILL;
                        miss_d  = (miss_q == '1) ? miss_q : miss_q + c_CNT_ONE;
                    end
                end
            end
            c_ST_WB: begin
                if (pmem_resp) begin
                    state_d = c_ST_FILL;
                    dirty_d = 1'b0;
                end
            end
            c_ST_FILL: begin
                if (pmem_resp) begin
                    state_d = c_ST_RESPOND;
                    line_d  = pmem_rdata;
                    tag_d   = mem_address[31:5];
                    valid_d = 1'b1;
                end
            end
            default: begin
                // Writes land in the held line as the single RESPOND cycle ends
                if (w_is_write) begin
                    line_d[w_bit_idx +: 32] = w_merged;
                    dirty_d                 = 1'b1;
                end
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            line_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state_q)
            c_ST_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q, 5'b0};
                pmem_wdata   = line_q;
            end
            c_ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:5], 5'b0};
            end
            c_ST_RESPOND: begin
                mem_resp  = 1'b1;
                mem_rdata = w_is_write ? w_merged : w_word;
            end
            default: ;
        endcase
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_pmem_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_line_buffer
// Function : self-checking bench for pmem_line_buffer with a reference line
//            model and a behavioural physical memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_line_buffer;

    localparam int CNT_W = 4;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             mem_read, mem_write;
    logic [31:0]      mem_address, mem_wdata;
    logic [3:0]       mem_byte_enable;
    logic             mem_resp;
    logic [31:0]      mem_rdata;
    logic             pmem_read, pmem_write;
    logic [31:0]      pmem_address;
    logic [255:0]     pmem_wdata;
    logic             pmem_resp;
    logic [255:0]     pmem_rdata;
    logic [CNT_W-1:0] hit_count, miss_count;

    pmem_line_buffer #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } pop_t;

    pop_t        pq[$];   // expected physical-memory transactions
    logic [31:0] rq[$];   // expected CPU read data
    int          lq[$];   // expected CPU latency, -1 when not checked

    // Word k of line t; line 0x100 (tag 8) holds word k = k
    function automatic logic [255:0] init_line(input logic [26:0] t);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[32*k +: 32] = ((32'(t) ^ 32'd8) << 8) | 32'(k);
        end
        return l;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    // Behavioural physical memory: latency LAT, one-cycle resp pulse
    logic [255:0] pm [logic [26:0]];

    initial begin
        pop_t         e;
        bit           wr;
        logic [31:0]  a;
        logic [255:0] d;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && (pmem_read || pmem_write)) begin
                if (pq.size() == 0) begin
                    chk("pmem_unexpected", {pmem_write, pmem_read}, 2'b00);
                end else begin
                    e = pq.pop_front();
                    chk("pmem_op", pmem_write, e.wr);
                    chk("pmem_addr", pmem_address, e.addr);
                    if (e.wr) chk("pmem_wdata", pmem_wdata, e.data);
                end
                wr = pmem_write;
                a  = pmem_address;
                d  = pmem_wdata;
                repeat (LAT - 1) @(negedge clk);
                pmem_resp = 1'b1;
                if (wr) pm[a[31:5]] = d;
                else    pmem_rdata = pm.exists(a[31:5]) ? pm[a[31:5]] : init_line(a[31:5]);
                @(negedge clk);
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
            end
        end
    end

    // Reference line model
    logic [255:0]     ref_bk [logic [26:0]];
    logic [255:0]     rline;
    logic [26:0]      rtag;
    bit               rv, rdirty;
    logic [CNT_W-1:0] ref_hit, ref_miss;

    task automatic ref_reset();
        rv = 0; rdirty = 0; ref_hit = '0; ref_miss = '0; rline = '0; rtag = '0;
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be);
        logic [26:0] t;
        int          s, cyc;
        bit          got;
        logic [31:0] exp;
        t = addr[31:5];
        s = int'(addr[4:2]);
        if (rv && rtag == t) begin
            ref_hit = sat(ref_hit);
            lq.push_back(1);
        end else begin
            ref_miss = sat(ref_miss);
            lq.push_back(-1);
            if (rdirty) begin
                pq.push_back('{1'b1, {rtag, 5'b0}, rline});
                ref_bk[rtag] = rline;
            end
            pq.push_back('{1'b0, {t, 5'b0}, '0});
            rline  = ref_bk.exists(t) ? ref_bk[t] : init_line(t);
            rtag   = t;
            rv     = 1;
            rdirty = 0;
        end
        if (wr) begin
            rline[32*s +: 32] = merge(rline[32*s +: 32], wd, be);
            rdirty = 1;
        end
        exp = rline[32*s +: 32];
        rq.push_back(exp);

        mem_read = !wr; mem_write = wr; mem_address = addr;
        mem_wdata = wd; mem_byte_enable = be;
        cyc = 0; got = 0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            if (mem_resp) got = 1;
        end
        if (!got) begin
            chk("resp_timeout", 1'b0, 1'b1);
            void'(rq.pop_front());
            void'(lq.pop_front());
        end else begin
            int l;
            chk("rdata", mem_rdata, rq.pop_front());
            l = lq.pop_front();
            if (l >= 0) chk("hit_latency", cyc, l);
            chk("hit_count", hit_count, ref_hit);
            chk("miss_count", miss_count, ref_miss);
        end
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
        @(negedge clk);
        chk("resp_pulse", mem_resp, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1; mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0;
        mem_byte_enable = '0;
        ref_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_resp", mem_resp, 1'b0);
        chk("rst_pmem_rw", {pmem_read, pmem_write}, 2'b00);
        chk("rst_pmem_addr", pmem_address, 32'h0);
        chk("rst_counters", {hit_count, miss_count}, '0);
        rst = 0;

        do_req(0, 32'h100, 32'h0, 4'h0);            // clean miss, word 0
        do_req(0, 32'h11C, 32'h0, 4'h0);            // hit, word 7
        do_req(1, 32'h104, 32'hAABBCCDD, 4'b0101);  // byte-enabled write
        do_req(0, 32'h104, 32'h0, 4'h0);
        chk("merged_word", mem_rdata === 32'h0 ? rline[63:32] : 32'hx, 32'h00BB00DD);
        do_req(0, 32'h200, 32'h0, 4'h0);            // dirty eviction then fill
        do_req(0, 32'h100, 32'h0, 4'h0);            // refill sees written-back data

        // High line: tag wrap region behaves as an ordinary line
        do_req(1, 32'hFFFF_FFFC, 32'h1234_5678, 4'b1111);
        do_req(0, 32'h0000_0000, 32'h0, 4'h0);
        do_req(0, 32'hFFFF_FFE0, 32'h0, 4'h0);
        do_req(0, 32'hFFFF_FFFC, 32'h0, 4'h0);

        for (int i = 0; i < 24; i++) begin
            do_req(1'($urandom_range(0, 1)),
                   32'h400 + 32'($urandom_range(0, 2)) * 32'h20 + 32'($urandom_range(0, 7)) * 4,
                   $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset during FILL: line 0x500 is never in the random set, so this is a miss
        if (rdirty) begin
            do_req(0, {rtag, 5'b0}, 32'h0, 4'h0);
            do_req(0, 32'h200, 32'h0, 4'h0);
        end
        do_req(0, 32'h600, 32'h0, 4'h0);
        pq.push_back('{1'b0, 32'h500, '0});
        mem_read = 1; mem_address = 32'h500;
        cyc = 0;
        while (cyc < 50 && !pmem_read) begin
            @(negedge clk);
            cyc++;
        end
        chk("fill_started", pmem_read, 1'b1);
        rst = 1; mem_read = 0;
        @(negedge clk);
        chk("midrst_mem_resp", mem_resp, 1'b0);
        chk("midrst_pmem_rw", {pmem_read, pmem_write}, 2'b00);
        chk("midrst_pmem_addr", pmem_address, 32'h0);
        chk("midrst_pmem_wdata", pmem_wdata, 256'h0);
        chk("midrst_counters", {hit_count, miss_count}, '0);
        rst = 0;
        ref_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stale_resp_ignored", {mem_resp, pmem_read, pmem_write}, 3'b000);
        end
        do_req(0, 32'h600, 32'h0, 4'h0);            // valid cleared: must refill

        for (int i = 0; i < 17; i++) begin
            do_req(0, 32'h600 + 32'(i % 8) * 4, 32'h0, 4'h0);
        end
        chk("hit_saturated", hit_count, {CNT_W{1'b1}});
        chk("pmem_queue_empty", pq.size(), 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
